// File: rtl/bsg_axil_host_pkg.sv
// Shared types and helpers for the AXI4-Lite host master: response codes,
// protection default and a clog2 that never returns a zero width.
package bsg_axil_host_pkg;

  typedef enum logic [1:0] {
    e_axil_okay   = 2'b00,
    e_axil_exokay = 2'b01,
    e_axil_slverr = 2'b10,
    e_axil_decerr = 2'b11
  } axil_resp_e;

  localparam logic [2:0] axil_prot_gp = 3'b000;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_axil_host_channel_ctr.sv
// Per-channel outstanding-transaction counter with issue credit and a
// sticky response-timeout watchdog.
module bsg_axil_host_channel_ctr
  import bsg_axil_host_pkg::*;
#(
  parameter int max_outstanding_p = 2,
  parameter int timeout_p         = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic issue_i,
  input  logic resp_i,
  output logic credit_o,
  output logic timeout_o
);
  localparam int cnt_w_lp = safe_clog2(max_outstanding_p + 1);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  // Simultaneous issue and response cancel; a stray response saturates at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (issue_i & ~resp_i)                        cnt_d = cnt_q + cnt_w_lp'(1);
    else if (resp_i & ~issue_i & (cnt_q != '0))   cnt_d = cnt_q - cnt_w_lp'(1);
  end

  assign credit_o = (cnt_q < cnt_w_lp'(max_outstanding_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always @(posedge clk_i) begin
    if (!reset_i && resp_i) assert (cnt_q != '0);
  end

  if (timeout_p == 0) begin : g_no_wd
    assign timeout_o = 1'b0;
  end else begin : g_wd
    localparam int tmr_w_lp = safe_clog2(timeout_p + 1);
    logic [tmr_w_lp-1:0] tmr_q, tmr_d;
    logic                flag_q, flag_d;

    always_comb begin
      tmr_d  = tmr_q;
      flag_d = flag_q;
      if ((cnt_q == '0) || resp_i)              tmr_d = '0;
      else if (tmr_q != tmr_w_lp'(timeout_p))   tmr_d = tmr_q + tmr_w_lp'(1);
      if (tmr_d == tmr_w_lp'(timeout_p))        flag_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        tmr_q  <= '0;
        flag_q <= 1'b0;
      end else begin
        tmr_q  <= tmr_d;
        flag_q <= flag_d;
      end
    end

    assign timeout_o = flag_q;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, registered output (no same-cycle bypass),
// valid/ready on the input and valid/yumi on the output.
module bsg_fifo_1r1w_small
  import bsg_axil_host_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam int cnt_w_lp = safe_clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                enq, deq;

  assign ready_o = (cnt_q != cnt_w_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_r[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (enq) wptr_d = (wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1);
    if (deq) rptr_d = (rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1);
    if (enq & ~deq)      cnt_d = cnt_q + cnt_w_lp'(1);
    else if (deq & ~enq) cnt_d = cnt_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_q] <= data_i;
  end

  always @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end

endmodule

// File: rtl/bsg_axil_host_master.sv
// AXI4-Lite master driven by host-side command FIFOs; write and read channels
// run independently, each with credit-limited issue and queued responses.
module bsg_axil_host_master
  import bsg_axil_host_pkg::*;
#(
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int cmd_els_p         = 4,
  parameter int resp_els_p        = 4,
  parameter int max_outstanding_p = 2,
  parameter int timeout_p         = 1024
) (
  input  logic                      aclk_i,
  input  logic                      areset_i,
  input  logic                      wr_cmd_v_i,
  input  logic [addr_width_p-1:0]   wr_cmd_addr_i,
  input  logic [data_width_p-1:0]   wr_cmd_data_i,
  input  logic [data_width_p/8-1:0] wr_cmd_strb_i,
  output logic                      wr_cmd_ready_o,
  input  logic                      rd_cmd_v_i,
  input  logic [addr_width_p-1:0]   rd_cmd_addr_i,
  output logic                      rd_cmd_ready_o,
  output logic                      wr_resp_v_o,
  output logic [1:0]                wr_resp_o,
  input  logic                      wr_resp_yumi_i,
  output logic                      rd_resp_v_o,
  output logic [data_width_p-1:0]   rd_resp_data_o,
  output logic [1:0]                rd_resp_o,
  input  logic                      rd_resp_yumi_i,
  output logic [1:0]                timeout_o,
  output logic [addr_width_p-1:0]   awaddr_o,
  output logic [2:0]                awprot_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [data_width_p-1:0]   wdata_o,
  output logic [data_width_p/8-1:0] wstrb_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  input  logic [1:0]                bresp_i,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  output logic [addr_width_p-1:0]   araddr_o,
  output logic [2:0]                arprot_o,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  input  logic [data_width_p-1:0]   rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rvalid_i,
  output logic                      rready_o
);
  localparam int strb_w_lp = data_width_p / 8;

  // Widths follow the module parameters, so the record layouts live here.
  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] data;
    logic [strb_w_lp-1:0]    strb;
  } wr_cmd_s;

  typedef struct packed {
    logic [addr_width_p-1:0] addr;
  } rd_cmd_s;

  typedef struct packed {
    logic [data_width_p-1:0] data;
    axil_resp_e              resp;
  } rd_resp_s;

  logic     live;
  wr_cmd_s  wr_cmd_in, wr_head;
  rd_cmd_s  rd_cmd_in, rd_head;
  rd_resp_s rd_resp_in, rd_resp_head;
  logic     wr_fifo_ready, wr_fifo_v, wr_deq, wr_credit;
  logic     rd_fifo_ready, rd_fifo_v, rd_deq, rd_credit;
  logic     b_fifo_ready, b_fifo_v, r_fifo_ready, r_fifo_v;
  logic     wr_issue_ok, aw_hs, w_hs, b_hs, r_hs;
  logic     aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
  logic     wr_to, rd_to;

  assign live = ~areset_i;

  assign wr_cmd_in  = '{addr: wr_cmd_addr_i, data: wr_cmd_data_i, strb: wr_cmd_strb_i};
  assign rd_cmd_in  = '{addr: rd_cmd_addr_i};
  assign rd_resp_in = '{data: rdata_i, resp: axil_resp_e'(rresp_i)};

  bsg_fifo_1r1w_small #(.width_p($bits(wr_cmd_s)), .els_p(cmd_els_p)) u_wr_fifo (
    .clk_i(aclk_i), .reset_i(areset_i), .v_i(wr_cmd_v_i), .ready_o(wr_fifo_ready),
    .data_i(wr_cmd_in), .v_o(wr_fifo_v), .data_o(wr_head), .yumi_i(wr_deq));

  bsg_fifo_1r1w_small #(.width_p($bits(rd_cmd_s)), .els_p(cmd_els_p)) u_rd_fifo (
    .clk_i(aclk_i), .reset_i(areset_i), .v_i(rd_cmd_v_i), .ready_o(rd_fifo_ready),
    .data_i(rd_cmd_in), .v_o(rd_fifo_v), .data_o(rd_head), .yumi_i(rd_deq));

  bsg_fifo_1r1w_small #(.width_p(2), .els_p(resp_els_p)) u_b_fifo (
    .clk_i(aclk_i), .reset_i(areset_i), .v_i(b_hs), .ready_o(b_fifo_ready),
    .data_i(bresp_i), .v_o(b_fifo_v), .data_o(wr_resp_o), .yumi_i(wr_resp_yumi_i));

  bsg_fifo_1r1w_small #(.width_p($bits(rd_resp_s)), .els_p(resp_els_p)) u_r_fifo (
    .clk_i(aclk_i), .reset_i(areset_i), .v_i(r_hs), .ready_o(r_fifo_ready),
    .data_i(rd_resp_in), .v_o(r_fifo_v), .data_o(rd_resp_head), .yumi_i(rd_resp_yumi_i));

  // Credit only shrinks on this channel's own dequeue, so a raised valid
  // cannot lose its credit before its handshake completes.
  assign wr_issue_ok = wr_fifo_v & wr_credit & live;
  assign awvalid_o   = wr_issue_ok & ~aw_sent_q;
  assign wvalid_o    = wr_issue_ok & ~w_sent_q;
  assign aw_hs       = awvalid_o & awready_i;
  assign w_hs        = wvalid_o & wready_i;
  assign wr_deq      = (aw_sent_q | aw_hs) & (w_sent_q | w_hs);

  always_comb begin
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    if (wr_deq) begin
      aw_sent_d = 1'b0;
      w_sent_d  = 1'b0;
    end else begin
      if (aw_hs) aw_sent_d = 1'b1;
      if (w_hs)  w_sent_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
    end
  end

  assign arvalid_o = rd_fifo_v & rd_credit & live;
  assign rd_deq    = arvalid_o & arready_i;

  assign bready_o = b_fifo_ready & live;
  assign rready_o = r_fifo_ready & live;
  assign b_hs     = bvalid_i & bready_o;
  assign r_hs     = rvalid_i & rready_o;

  bsg_axil_host_channel_ctr #(.max_outstanding_p(max_outstanding_p), .timeout_p(timeout_p)) u_wr_ctr (
    .clk_i(aclk_i), .reset_i(areset_i), .issue_i(wr_deq), .resp_i(b_hs),
    .credit_o(wr_credit), .timeout_o(wr_to));

  bsg_axil_host_channel_ctr #(.max_outstanding_p(max_outstanding_p), .timeout_p(timeout_p)) u_rd_ctr (
    .clk_i(aclk_i), .reset_i(areset_i), .issue_i(rd_deq), .resp_i(r_hs),
    .credit_o(rd_credit), .timeout_o(rd_to));

  assign wr_cmd_ready_o = wr_fifo_ready & live;
  assign rd_cmd_ready_o = rd_fifo_ready & live;
  assign wr_resp_v_o    = b_fifo_v & live;
  assign rd_resp_v_o    = r_fifo_v & live;
  assign rd_resp_data_o = rd_resp_head.data;
  assign rd_resp_o      = rd_resp_head.resp;
  assign timeout_o      = {rd_to, wr_to};

  assign awaddr_o = wr_head.addr;
  assign wdata_o  = wr_head.data;
  assign wstrb_o  = wr_head.strb;
  assign araddr_o = rd_head.addr;
  assign awprot_o = axil_prot_gp;
  assign arprot_o = axil_prot_gp;

endmodule

// File: tb/tb_bsg_axil_host_master.sv
// Directed bench for bsg_axil_host_master: a vector table of single
// transactions plus hand sequences for skew, credit, backpressure, watchdog, reset.
module tb_bsg_axil_host_master;

  logic        aclk = 1'b0;
  logic        areset_i;
  logic        wr_cmd_v_i, wr_cmd_ready_o, rd_cmd_v_i, rd_cmd_ready_o;
  logic [31:0] wr_cmd_addr_i, wr_cmd_data_i, rd_cmd_addr_i;
  logic [3:0]  wr_cmd_strb_i;
  logic        wr_resp_v_o, wr_resp_yumi_i, rd_resp_v_o, rd_resp_yumi_i;
  logic [1:0]  wr_resp_o, rd_resp_o, timeout_o;
  logic [31:0] rd_resp_data_o;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0]  awprot_o, arprot_o;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o;
  logic [1:0]  bresp_i, rresp_i;

  always #5 aclk = ~aclk;

  bsg_axil_host_master #(
    .addr_width_p(32), .data_width_p(32), .cmd_els_p(4), .resp_els_p(4),
    .max_outstanding_p(2), .timeout_p(16)
  ) dut (
    .aclk_i(aclk), .areset_i(areset_i),
    .wr_cmd_v_i(wr_cmd_v_i), .wr_cmd_addr_i(wr_cmd_addr_i), .wr_cmd_data_i(wr_cmd_data_i),
    .wr_cmd_strb_i(wr_cmd_strb_i), .wr_cmd_ready_o(wr_cmd_ready_o),
    .rd_cmd_v_i(rd_cmd_v_i), .rd_cmd_addr_i(rd_cmd_addr_i), .rd_cmd_ready_o(rd_cmd_ready_o),
    .wr_resp_v_o(wr_resp_v_o), .wr_resp_o(wr_resp_o), .wr_resp_yumi_i(wr_resp_yumi_i),
    .rd_resp_v_o(rd_resp_v_o), .rd_resp_data_o(rd_resp_data_o), .rd_resp_o(rd_resp_o),
    .rd_resp_yumi_i(rd_resp_yumi_i), .timeout_o(timeout_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    int          dly;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t  vecs [6];
  int    n_cmp = 0;
  int    n_err = 0;
  string tag   = "init";
  int    ar_hs_cnt = 0;

  always @(posedge aclk) if (arvalid_o && arready_i) ar_hs_cnt <= ar_hs_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.wr) begin
      wr_cmd_addr_i = v.addr; wr_cmd_data_i = v.data; wr_cmd_strb_i = v.strb; wr_cmd_v_i = 1'b1;
      chk("wr_cmd_ready", wr_cmd_ready_o, 1);
      chk("no_bypass_aw", awvalid_o, 0);
      step(); wr_cmd_v_i = 1'b0;
      chk("aw_w_valid", {awvalid_o, wvalid_o}, 2'b11);
      repeat (v.dly) begin step(); chk("aw_w_hold", {awvalid_o, wvalid_o}, 2'b11); end
      chk("awaddr", awaddr_o, v.exp_addr);
      chk("wdata", wdata_o, v.exp_data);
      chk("wstrb", wstrb_o, v.exp_strb);
      chk("awprot", awprot_o, 0);
      awready_i = 1'b1; wready_i = 1'b1;
      step(); awready_i = 1'b0; wready_i = 1'b0;
      chk("aw_w_drop", {awvalid_o, wvalid_o}, 0);
      bvalid_i = 1'b1; bresp_i = v.sresp;
      chk("bready", bready_o, 1);
      step(); bvalid_i = 1'b0;
      chk("wr_resp_v", wr_resp_v_o, 1);
      chk("wr_resp", wr_resp_o, v.exp_resp);
      wr_resp_yumi_i = 1'b1;
      step(); wr_resp_yumi_i = 1'b0;
      chk("wr_resp_pop", wr_resp_v_o, 0);
    end else begin
      rd_cmd_addr_i = v.addr; rd_cmd_v_i = 1'b1;
      chk("rd_cmd_ready", rd_cmd_ready_o, 1);
      chk("no_bypass_ar", arvalid_o, 0);
      step(); rd_cmd_v_i = 1'b0;
      chk("arvalid", arvalid_o, 1);
      repeat (v.dly) begin step(); chk("ar_hold", arvalid_o, 1); end
      chk("araddr", araddr_o, v.exp_addr);
      chk("arprot", arprot_o, 0);
      arready_i = 1'b1;
      step(); arready_i = 1'b0;
      chk("ar_drop", arvalid_o, 0);
      rvalid_i = 1'b1; rdata_i = v.data; rresp_i = v.sresp;
      chk("rready", rready_o, 1);
      step(); rvalid_i = 1'b0;
      chk("rd_resp_v", rd_resp_v_o, 1);
      chk("rd_resp_data", rd_resp_data_o, v.exp_data);
      chk("rd_resp", rd_resp_o, v.exp_resp);
      rd_resp_yumi_i = 1'b1;
      step(); rd_resp_yumi_i = 1'b0;
      chk("rd_resp_pop", rd_resp_v_o, 0);
    end
  endtask

  // Enqueue one read, accept its AR, and return an R beat with the given data.
  task automatic simple_read(input logic [31:0] addr, input logic [31:0] data);
    rd_cmd_addr_i = addr; rd_cmd_v_i = 1'b1;
    step(); rd_cmd_v_i = 1'b0; arready_i = 1'b1;
    step(); arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = data; rresp_i = 2'b00;
    step(); rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int base;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0, 2, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd0};
    vecs[1] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'h3, 2'd2, 0, 32'h0000_0024, 32'h1234_5678, 4'h3, 2'd2};
    vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 2'd3, 1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 2'd3};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'hCAFE_F00D, 4'h0, 2'd0, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'h0, 2'd0};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 2'd1, 0, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 2'd1};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'd2, 3, 32'h0000_0000, 32'h0000_0000, 4'h0, 2'd2};

    areset_i = 1'b1;
    wr_cmd_v_i = 0; wr_cmd_addr_i = 0; wr_cmd_data_i = 0; wr_cmd_strb_i = 0;
    rd_cmd_v_i = 0; rd_cmd_addr_i = 0; wr_resp_yumi_i = 0; rd_resp_yumi_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0;

    tag = "reset";
    step(); step();
    chk("valids_readys_in_reset",
        {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, wr_cmd_ready_o, rd_cmd_ready_o, wr_resp_v_o, rd_resp_v_o}, 0);
    chk("timeout_in_reset", timeout_o, 0);
    areset_i = 1'b0;
    step();
    chk("readys_after_reset", {wr_cmd_ready_o, rd_cmd_ready_o, bready_o, rready_o}, 4'hF);
    chk("valids_after_reset", {awvalid_o, wvalid_o, arvalid_o, wr_resp_v_o, rd_resp_v_o}, 0);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      run_vec(vecs[i]);
    end

    // AW accepted the cycle after enqueue, W five cycles later.
    tag = "skew";
    wr_cmd_addr_i = 32'h40; wr_cmd_data_i = 32'hA5A5_0001; wr_cmd_strb_i = 4'hF; wr_cmd_v_i = 1'b1;
    step(); wr_cmd_v_i = 1'b0; awready_i = 1'b1;
    step(); awready_i = 1'b0;
    chk("aw_dropped_w_held", {awvalid_o, wvalid_o}, 2'b01);
    repeat (4) step();
    chk("w_still_held", {awvalid_o, wvalid_o}, 2'b01);
    wready_i = 1'b1;
    step(); wready_i = 1'b0;
    chk("both_low_after_w", {awvalid_o, wvalid_o}, 0);
    chk("wr_outstanding_1", dut.u_wr_ctr.cnt_q, 1);
    step();
    chk("single_dequeue", {awvalid_o, wvalid_o}, 0);
    bvalid_i = 1'b1; bresp_i = 2'b00;
    step(); bvalid_i = 1'b0;
    wr_resp_yumi_i = 1'b1;
    step(); wr_resp_yumi_i = 1'b0;
    chk("wr_outstanding_0", dut.u_wr_ctr.cnt_q, 0);

    // Four reads queued with only two credits.
    tag = "credit";
    base = ar_hs_cnt;
    arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_cmd_addr_i = 32'h100 + 32'(i * 4); rd_cmd_v_i = 1'b1;
      step();
    end
    rd_cmd_v_i = 1'b0;
    repeat (4) step();
    chk("ar_hs_limited", ar_hs_cnt - base, 2);
    chk("arvalid_blocked", arvalid_o, 0);
    rvalid_i = 1'b1; rdata_i = 32'd0; rresp_i = 2'b00;
    step(); rvalid_i = 1'b0;
    chk("ar3_after_first_r", arvalid_o, 1);
    step();
    for (int d = 1; d < 4; d++) begin
      rvalid_i = 1'b1; rdata_i = 32'(d);
      step(); rvalid_i = 1'b0;
      step();
    end
    arready_i = 1'b0;
    chk("ar_hs_total", ar_hs_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("credit_resp_v", rd_resp_v_o, 1);
      chk("credit_resp_order", rd_resp_data_o, 32'(i));
      rd_resp_yumi_i = 1'b1;
      step(); rd_resp_yumi_i = 1'b0;
    end

    // Response FIFO fills with the host not consuming.
    tag = "backpressure";
    for (int i = 0; i < 4; i++) simple_read(32'h200 + 32'(i * 4), 32'h100 + 32'(i));
    chk("rready_full", rready_o, 0);
    rd_cmd_addr_i = 32'h210; rd_cmd_v_i = 1'b1;
    step(); rd_cmd_v_i = 1'b0; arready_i = 1'b1;
    step(); arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'h104; rresp_i = 2'b00;
    repeat (3) begin step(); chk("rready_held_low", rready_o, 0); end
    chk("head_while_full", rd_resp_data_o, 32'h100);
    rd_resp_yumi_i = 1'b1;
    step(); rd_resp_yumi_i = 1'b0;
    chk("rready_restored", rready_o, 1);
    step(); rvalid_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("drain_v", rd_resp_v_o, 1);
      chk("drain_data", rd_resp_data_o, 32'h100 + 32'(i));
      rd_resp_yumi_i = 1'b1;
      step(); rd_resp_yumi_i = 1'b0;
    end
    chk("drained_empty", rd_resp_v_o, 0);

    // Write issued, B withheld past the timeout.
    tag = "watchdog";
    areset_i = 1'b1;
    step(); areset_i = 1'b0;
    step();
    chk("timeout_clear", timeout_o, 0);
    wr_cmd_addr_i = 32'h80; wr_cmd_data_i = 32'h5; wr_cmd_strb_i = 4'h1; wr_cmd_v_i = 1'b1;
    step(); wr_cmd_v_i = 1'b0; awready_i = 1'b1; wready_i = 1'b1;
    step(); awready_i = 1'b0; wready_i = 1'b0;
    repeat (15) step();
    chk("wd_not_yet", timeout_o, 2'b00);
    step();
    chk("wd_fires_16", timeout_o, 2'b01);
    bvalid_i = 1'b1; bresp_i = 2'b00;
    step(); bvalid_i = 1'b0;
    chk("wd_sticky", timeout_o, 2'b01);
    wr_resp_yumi_i = 1'b1;
    step(); wr_resp_yumi_i = 1'b0;
    repeat (3) step();
    chk("wd_sticky_rd_clear", timeout_o, 2'b01);

    // Reset with a write pending on AW/W and two reads outstanding.
    tag = "reset_mid";
    arready_i = 1'b1;
    rd_cmd_addr_i = 32'h300; rd_cmd_v_i = 1'b1;
    step(); rd_cmd_addr_i = 32'h304;
    step(); rd_cmd_v_i = 1'b0;
    step(); arready_i = 1'b0;
    chk("rd_outstanding_2", dut.u_rd_ctr.cnt_q, 2);
    wr_cmd_addr_i = 32'h400; wr_cmd_data_i = 32'h77; wr_cmd_strb_i = 4'hF; wr_cmd_v_i = 1'b1;
    step(); wr_cmd_v_i = 1'b0;
    chk("awvalid_pending", awvalid_o, 1);
    areset_i = 1'b1;
    #1;
    chk("all_low_at_reset",
        {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, wr_cmd_ready_o, rd_cmd_ready_o, wr_resp_v_o, rd_resp_v_o}, 0);
    step(); areset_i = 1'b0;
    step();
    chk("rd_ctr_cleared", dut.u_rd_ctr.cnt_q, 0);
    chk("wr_ctr_cleared", dut.u_wr_ctr.cnt_q, 0);
    chk("fifos_empty", {awvalid_o, arvalid_o, wr_resp_v_o, rd_resp_v_o}, 0);
    chk("timeout_reset", timeout_o, 0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_axil_host_master.md
Name: bsg_axil_host_master

Overview:
Parametrised successor to the DPI-driven AXI-lite master shim. Host-side valid/ready command queues feed a fully sequenced AXI4-Lite master, so a host can issue commands without sequencing each AXI wire itself.
- Separate write and read command FIFOs; queued responses back to the host.
- Bounded outstanding transactions per channel.
- Per-channel response timeout watchdog.
Sits between the cosim host bridge (or a PS-side command source) and any AXI-lite slave in the shell.

Parameters:
addr_width_p, 32, AXI address width
data_width_p, 32, AXI data width; multiple of 8
cmd_els_p, 4, depth of each command FIFO; >=2
resp_els_p, 4, depth of each response FIFO; >=2
max_outstanding_p, 2, max in-flight transactions per channel; >=1
timeout_p, 1024, cycles without a response before timeout flag; 0 disables the watchdog

Ports:
aclk_i  in  1  clock
areset_i  in  1  asynchronous active-high reset
wr_cmd_v_i  in  1  write command valid
wr_cmd_addr_i  in  addr_width_p  write address
wr_cmd_data_i  in  data_width_p  write data
wr_cmd_strb_i  in  data_width_p/8  byte strobes
wr_cmd_ready_o  out  1  write FIFO not full
rd_cmd_v_i  in  1  read command valid
rd_cmd_addr_i  in  addr_width_p  read address
rd_cmd_ready_o  out  1  read FIFO not full
wr_resp_v_o  out  1  write response available
wr_resp_o  out  2  BRESP
wr_resp_yumi_i  in  1  host consumes write response
rd_resp_v_o  out  1  read response available
rd_resp_data_o  out  data_width_p  RDATA
rd_resp_o  out  2  RRESP
rd_resp_yumi_i  in  1  host consumes read response
timeout_o  out  2  sticky timeout flags, [0]=write, [1]=read
AW/W/B/AR/R channels: awaddr_o, awprot_o[2:0], awvalid_o, awready_i, wdata_o, wstrb_o, wvalid_o, wready_i, bresp_i[1:0], bvalid_i, bready_o, araddr_o, arprot_o[2:0], arvalid_o, arready_i, rdata_i, rresp_i[1:0], rvalid_i, rready_o. Widths follow the parameters.

Behaviour:
- Reset: asynchronous, active-high, clears all FIFOs, counters, sent flags and timeout_o. While areset_i is high, every valid/ready output is 0; *prot_o is always 3'b000.
- Command FIFOs: enqueue on v_i & ready_o. Zero-cycle bypass is forbidden; the earliest AXI valid is the cycle after the enqueue.
- Write issue: when the write FIFO is non-empty and wr_outstanding < max_outstanding_p, drive awvalid_o and wvalid_o with the FIFO head.
  - aw_sent/w_sent flags record each accepted handshake.
  - A valid output never deasserts before its ready; after its handshake it drops until the next head.
  - Dequeue when both sent, or both handshake in the same cycle. On dequeue, increment wr_outstanding and clear the flags.
- Read issue: arvalid_o when the FIFO is non-empty and rd_outstanding < max_outstanding_p. Dequeue and increment on arvalid_o & arready_i.
- Responses: bready_o = write response FIFO not full; rready_o = read response FIFO not full. A B/R handshake enqueues the response and decrements the matching counter.
  - Issue and response in the same cycle: counter unchanged.
  - A response with counter 0 is a protocol violation: assert in simulation; the counter saturates at 0.
- Response FIFO output: v_o = non-empty; head is valid while v_o is high; yumi_i pops. yumi_i with v_o low is illegal (assert).
- Watchdog, per channel, when timeout_p != 0:
  - Counter clears when outstanding == 0 or on a response handshake; otherwise it increments, saturating at timeout_p.
  - Reaching timeout_p sets the sticky timeout_o bit, cleared only by reset.
  - Traffic continues unaffected.
- Ordering: the write and read channels are independent, with no ordering between them. Within a channel, responses come back in issue order (AXI-lite).

Decomposition:
- Package bsg_axil_host_pkg: resp enum (OKAY, EXOKAY, SLVERR, DECERR); structs for wr_cmd {addr, data, strb}, rd_cmd {addr}, rd_resp {data, resp}.
- One sub-module: bsg_axil_host_channel_ctr, an outstanding counter plus watchdog, instantiated twice.
- FIFOs use the existing bsg_fifo_1r1w_small.

Test Plan:
- Single write: addr 0x10, data 0xDEADBEEF, strb 0xF; slave awready/wready after 2 cycles, bvalid OKAY -> one AW and one W handshake with matching fields; wr_resp_v_o with resp 0; wr_cmd_ready_o high throughout.
- AW/W skew: awready the cycle after enqueue, wready 5 cycles later -> awvalid_o drops after its handshake, wvalid_o holds; single dequeue; outstanding ends at 1.
- Credit limit: max_outstanding_p=2, 4 reads queued, slave withholds rvalid -> exactly 2 AR handshakes; 3rd arvalid_o only after the first R; 4 rd_resp in order with data 0,1,2,3.
- Backpressure: 4 reads complete with rd_resp_yumi_i held low -> rready_o drops once the response FIFO is full; no R data lost; draining restores rready_o.
- Watchdog: timeout_p=16, write issued, bvalid never -> timeout_o=2'b01 exactly 16 cycles after the dequeue; holds after a late B; read flag stays 0.
- Reset mid-transaction: areset_i pulsed while awvalid_o=1 and 2 reads outstanding -> all valids/readys 0 at once; counters and FIFOs empty; a new write after reset completes normally.
